imc_result_fifo: RTL
====================

# imc_result_fifo

Output-side stage for the in-memory-compute macro. Captures each 64-bit result vector (sixteen 4-bit ADC codes) when the controller flags data ready, queues the vectors in a small FIFO, and serves them to the management SoC over Wishbone as two 32-bit words. Sits directly downstream of the SRAM wrapper's ADC outputs and upstream of the user-project Wishbone read mux.

## Interface
Parameters:
- DEPTH, 8: FIFO entries, each 64 bits; power of two, 2..64.
- IRQ_THRESH, 4: occupancy at or above which irq_o asserts (only with IMC_RESULT_IRQ_EN).

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  reset, synchronous, active-low.
- imc_valid  in  1  one-cycle pulse: imc_data holds a new result vector.
- imc_data  in  64  ADC codes; ADCk at bits [4k+3:4k].
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_adr_i  in  32  byte address; only [3:2] decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid while ack high.
- fifo_empty  out  1  occupancy == 0.
- fifo_full  out  1  occupancy == DEPTH.
- irq_o  out  1  occupancy interrupt.

## Operation
- Register map (adr[3:2]): 0 DATA_LO (RO, head[31:0], no pop); 1 DATA_HI (RO, head[63:32], pops head); 2 STATUS (RO); 3 CTRL (WO).
- STATUS: [0] empty, [1] full, [2] overflow (sticky), [3] underflow (sticky), [15:8] occupancy, others 0.
- CTRL write: bit0 = flush (pointers and occupancy to 0, data not cleared); bit1 = clear overflow and underflow. Writes to 0–2 are acked and ignored; reads of 3 return 0.
- Push: imc_valid with FIFO not full stores imc_data at the write pointer. imc_valid while full with no pop in the same cycle drops the vector and sets overflow.
- Pop: a read of DATA_HI with FIFO not empty advances the read pointer.
- Read of DATA_LO or DATA_HI while empty: returns 0x0000_0000, no pop, sets underflow.
- Simultaneous push and pop: both take effect, occupancy unchanged. This also applies when full, because the pop frees the slot first.
- Flush in the same cycle as imc_valid: flush wins, vector discarded, overflow unchanged.
- Pointers wrap modulo DEPTH. Occupancy is a separate counter of width log2(DEPTH)+1.
- Reset state: pointers and occupancy 0, stickies 0, wbs_ack_o=0, wbs_dat_o=0, fifo_empty=1, fifo_full=0, irq_o=0.

## Timing
- Wishbone: a request is accepted in a cycle with stb & cyc & !ack. wbs_ack_o and wbs_dat_o are registered and appear the next cycle, high for exactly one cycle.
- Back-to-back requests complete at most every 2 cycles. A request held through the ack cycle is not re-accepted.
- Pop, flush and sticky updates take effect in the same edge that raises ack.
- Push: imc_valid sampled at edge N; fifo_empty, occupancy and STATUS reflect it after edge N. A DATA_LO read accepted in cycle N+1 returns the new entry.
- fifo_empty, fifo_full and irq_o are registered and update on the same edge as occupancy.
- reset_n low at an edge overrides everything, including an in-flight Wishbone access: ack suppressed and the FIFO emptied.

## Configuration
- IMC_RESULT_IRQ_EN defined: irq_o = (occupancy >= IRQ_THRESH) | overflow, registered, level-sensitive. irq_o clears when the FIFO is drained below the threshold and the stickies are cleared.
- IMC_RESULT_IRQ_EN undefined: irq_o tied 0, no comparator logic. IRQ_THRESH is ignored.

## Test plan
- Reset, then read STATUS -> 0x0000_0001. irq_o = 0, ack exactly 1 cycle after request.
- Push 0x0123_4567_89AB_CDEF, read DATA_LO then DATA_HI -> 0x89AB_CDEF, 0x0123_4567. STATUS then 0x0000_0001.
- Push 9 vectors with DEPTH=8 -> fifo_full=1 after the 8th, STATUS = 0x0000_0806. Popping yields the first 8 in order; the 9th is lost.
- FIFO full: imc_valid in the same cycle a DATA_HI read is accepted -> occupancy stays 8, no overflow, and the new vector is returned last.
- Read DATA_HI while empty -> 0x0000_0000, STATUS = 0x0000_0009. CTRL write 0x2 -> STATUS = 0x0000_0001.
- With IMC_RESULT_IRQ_EN, push 4 vectors -> irq_o rises after the 4th push edge; one pop -> irq_o falls. Without the macro, irq_o stays 0 throughout.

Source files
------------

// File: rtl/imc_result_fifo_if.sv
// Wishbone slave bus between the management SoC and the IMC result FIFO.
interface imc_result_fifo_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/imc_result_fifo.sv
// Queues 64-bit IMC result vectors and serves them over Wishbone as two 32-bit words.
// Optional occupancy/overflow interrupt enabled by defining IMC_RESULT_IRQ_EN.
module imc_result_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned IRQ_THRESH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    imc_valid,
  input  logic [63:0]             imc_data,
  imc_result_fifo_if.slave        wbs,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    irq_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, wptr_nxt, rptr_nxt;
  logic [OW-1:0] occ_q, occ_nxt;
  logic          ovf_q, udf_q, ovf_nxt, udf_nxt;
  logic          ack_q, empty_q, full_q;
  logic [31:0]   dat_q, rdata;
  logic [63:0]   head;
  logic [1:0]    sel;
  logic          accept_c, rd_c, wr_c, pop_c, push_c, flush_c, clr_c;
  logic          ovf_set_c, udf_set_c;

  // Request decode and next-state computation
  always_comb begin
    sel       = wbs.wbs_adr_i[3:2];
    accept_c  = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
    rd_c      = accept_c & ~wbs.wbs_we_i;
    wr_c      = accept_c & wbs.wbs_we_i;
    flush_c   = wr_c & (sel == 2'd3) & wbs.wbs_dat_i[0];
    clr_c     = wr_c & (sel == 2'd3) & wbs.wbs_dat_i[1];
    pop_c     = rd_c & (sel == 2'd1) & ~empty_q;
    // A pop frees the head slot first, so a full FIFO can still accept
    push_c    = imc_valid & (~full_q | pop_c) & ~flush_c;
    ovf_set_c = imc_valid & full_q & ~pop_c & ~flush_c;
    udf_set_c = rd_c & ((sel == 2'd0) | (sel == 2'd1)) & empty_q;

    occ_nxt  = occ_q + OW'(push_c) - OW'(pop_c);
    wptr_nxt = push_c ? wptr_q + AW'(1) : wptr_q;
    rptr_nxt = pop_c  ? rptr_q + AW'(1) : rptr_q;
    if (flush_c) begin
      occ_nxt  = '0;
      wptr_nxt = '0;
      rptr_nxt = '0;
    end
    ovf_nxt = (ovf_q & ~clr_c) | ovf_set_c;
    udf_nxt = (udf_q & ~clr_c) | udf_set_c;

    head  = mem[rptr_q];
    rdata = '0;
    case (sel)
      2'd0:    rdata = empty_q ? 32'h0 : head[31:0];
      2'd1:    rdata = empty_q ? 32'h0 : head[63:32];
      2'd2:    rdata = {16'h0, 8'(occ_q), 4'h0, udf_q, ovf_q, full_q, empty_q};
      default: rdata = '0;
    endcase
  end

  // Result storage; contents survive flush and reset
  always_ff @(posedge clk) begin
    if (reset_n && push_c) mem[wptr_q] <= imc_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_nxt;
      rptr_q  <= rptr_nxt;
      occ_q   <= occ_nxt;
      ovf_q   <= ovf_nxt;
      udf_q   <= udf_nxt;
      ack_q   <= accept_c;
      dat_q   <= rd_c ? rdata : 32'h0;
      empty_q <= (occ_nxt == '0);
      full_q  <= (occ_nxt == OW'(DEPTH));
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign fifo_empty    = empty_q;
  assign fifo_full     = full_q;

`ifdef IMC_RESULT_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= (occ_nxt >= OW'(IRQ_THRESH)) | ovf_nxt;
  end

  assign irq_o = irq_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(IRQ_THRESH);
  assign irq_o      = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:2]};
endmodule
